// File: rtl/golden_data_memory_pkg.sv
// Shared architecture constants and address decode for the golden data memory.
// MMIO registers sit in the top four words of the address space.
package golden_data_memory_pkg;

    localparam int unsigned ARCH_ADDRESS_SIZE = 8;
    localparam int unsigned ARCH_DATA_SIZE    = 32;
    localparam int unsigned ARCH_TX_DEPTH     = 4;

    // Offsets below TOP (TOP = 2^ADDRESS_SIZE-1).
    localparam int unsigned MMIO_TX_DATA_OFFSET   = 3;
    localparam int unsigned MMIO_TX_STATUS_OFFSET = 2;
    localparam int unsigned MMIO_TIMER_OFFSET     = 1;
    localparam int unsigned MMIO_DROPS_OFFSET     = 0;

    typedef enum logic [2:0] {
        RegionRam,
        RegionTxData,
        RegionTxStatus,
        RegionTimer,
        RegionDrops
    } region_e;

    // Status word layout: {full, empty, count}, count is log2(depth)+1 bits wide.
    function automatic int unsigned tx_count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned tx_status_empty_bit(input int unsigned depth);
        return tx_count_width(depth);
    endfunction

    function automatic int unsigned tx_status_full_bit(input int unsigned depth);
        return tx_count_width(depth) + 1;
    endfunction

    function automatic region_e decode_region(input int unsigned dist_from_top);
        region_e region;
        if (dist_from_top == MMIO_TX_DATA_OFFSET) begin
            region = RegionTxData;
        end else if (dist_from_top == MMIO_TX_STATUS_OFFSET) begin
            region = RegionTxStatus;
        end else if (dist_from_top == MMIO_TIMER_OFFSET) begin
            region = RegionTimer;
        end else if (dist_from_top == MMIO_DROPS_OFFSET) begin
            region = RegionDrops;
        end else begin
            region = RegionRam;
        end
        return region;
    endfunction

endpackage

// File: rtl/golden_tx_fifo.sv
// TX FIFO: power-of-two ring buffer; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module golden_tx_fifo #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TX_DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_SIZE-1:0]         push_data,
    input  logic                         pop,
    output logic [DATA_SIZE-1:0]         head_data,
    output logic [$clog2(TX_DEPTH):0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PtrWidth   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CountWidth = $clog2(TX_DEPTH) + 1;

    logic [DATA_SIZE-1:0]  storage_q [TX_DEPTH];
    logic [PtrWidth-1:0]   head_q, head_d;
    logic [PtrWidth-1:0]   tail_q, tail_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CountWidth'(TX_DEPTH));
    assign count = count_q;
    // Zero when empty so stale storage never leaks onto the output.
    assign head_data = empty ? '0 : storage_q[head_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = head_q + PtrWidth'(1);
        end
        if (do_push) begin
            tail_d = tail_q + PtrWidth'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            storage_q[tail_q] <= push_data;
        end
    end

endmodule

// File: rtl/golden_data_memory.sv
// Core data memory: RAM plus TX FIFO, free-running timer and drop counter MMIO
// registers. Reads are combinational so the core consumes data in the same cycle.
module golden_data_memory
    import golden_data_memory_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = ARCH_ADDRESS_SIZE,
    parameter int unsigned DATA_SIZE    = ARCH_DATA_SIZE,
    parameter int unsigned TX_DEPTH     = ARCH_TX_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [DATA_SIZE-1:0]    data_in,
    output logic [DATA_SIZE-1:0]    data_out,
    output logic [DATA_SIZE-1:0]    tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    localparam int unsigned RamWords   = (2 ** ADDRESS_SIZE) - 4;
    localparam int unsigned CountWidth = tx_count_width(TX_DEPTH);

    logic [DATA_SIZE-1:0]    mem [RamWords];
    logic [ADDRESS_SIZE-1:0] dist_from_top;
    region_e                 region;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty, tx_drop;
    logic [CountWidth-1:0]   fifo_count;
    logic [DATA_SIZE-1:0]    status_word;

    logic [DATA_SIZE-1:0]    timer_q, timer_d;
    logic [DATA_SIZE-1:0]    drops_q, drops_d;

    // TOP - address is simply the bitwise complement of the address.
    assign dist_from_top = ~address;
    assign region        = decode_region(32'(dist_from_top));

    assign fifo_push = write && (region == RegionTxData);
    assign fifo_pop  = tx_ready && !fifo_empty;
    // A full FIFO can only absorb the push if it pops on the same edge.
    assign tx_drop   = fifo_push && fifo_full && !fifo_pop;

    golden_tx_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .TX_DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (data_in),
        .pop       (fifo_pop),
        .head_data (tx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_valid    = !fifo_empty;
    assign status_word = DATA_SIZE'({fifo_full, fifo_empty, fifo_count});

    always_comb begin
        data_out = '0;
        if (read) begin
            unique case (region)
                RegionRam:      data_out = mem[address];
                RegionTxData:   data_out = '0;
                RegionTxStatus: data_out = status_word;
                RegionTimer:    data_out = timer_q;
                RegionDrops:    data_out = drops_q;
                default:        data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (write && (region == RegionRam)) begin
            mem[address] <= data_in;
        end
    end

    always_comb begin
        timer_d = timer_q + DATA_SIZE'(1);
        if (write && (region == RegionTimer)) begin
            timer_d = data_in;
        end

        drops_d = drops_q;
        // Clear takes priority over a coincident drop.
        if (write && (region == RegionDrops)) begin
            drops_d = '0;
        end else if (tx_drop && (drops_q != '1)) begin
            drops_d = drops_q + DATA_SIZE'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            drops_q <= '0;
        end else begin
            timer_q <= timer_d;
            drops_q <= drops_d;
        end
    end

endmodule
